// File: rtl/openmips_min_sopc_pkg.sv
// Shared constants for the OpenMIPS minimal SoC: bus widths, memory geometry,
// opcodes and the internal pipeline control encodings.
package defines;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic WRITE   = 1'b1;
  localparam logic READ    = 1'b0;

  localparam int INST_ADDR_BUS = 32;
  localparam int DATA_BUS      = 32;
  localparam int INST_MEM_NUM  = 131072;
  localparam int DATA_MEM_NUM  = 131072;
  localparam int MEM_IDX_W     = 17;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_COP0    = 6'b010000;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_LL      = 6'b110000;
  localparam logic [5:0] OP_SC      = 6'b111000;

  typedef enum logic [2:0] {ALU_OR, ALU_AND, ALU_XOR, ALU_ADD, ALU_SUB, ALU_LUI} alu_op_e;
  typedef enum logic [3:0] {
    MEM_NONE, MEM_LW, MEM_LB, MEM_LBU, MEM_SB, MEM_SW, MEM_LL, MEM_SC, MEM_ERET
  } mem_op_e;

  function automatic logic [MEM_IDX_W-1:0] mem_idx(input logic [31:0] addr);
    return addr[MEM_IDX_W+1:2];
  endfunction

endpackage

// File: rtl/data_ram.sv
// Data RAM as four byte banks (bank0 = bits 7:0) with per-byte write enables,
// synchronous write and combinational full-word read.
module data_ram
  import defines::*;
#(
  parameter int DATA_MEM_WORDS = DATA_MEM_NUM
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ce,
  input  logic                we,
  input  logic [3:0]          sel,
  input  logic [31:0]         addr,
  input  logic [DATA_BUS-1:0] wdata,
  output logic [DATA_BUS-1:0] rdata
);
  logic [7:0] bank0 [0:DATA_MEM_WORDS-1];
  logic [7:0] bank1 [0:DATA_MEM_WORDS-1];
  logic [7:0] bank2 [0:DATA_MEM_WORDS-1];
  logic [7:0] bank3 [0:DATA_MEM_WORDS-1];
  logic [MEM_IDX_W-1:0] idx;
  logic unused_addr;

  assign idx = mem_idx(addr);
  assign unused_addr = ^{addr[31:MEM_IDX_W+2], addr[1:0]};

  // Contents survive reset; reset only blocks the access.
  always_ff @(posedge clk) begin
    if (rst && ce == ENABLE && we == WRITE) begin
      if (sel[0]) bank0[idx] <= wdata[7:0];
      if (sel[1]) bank1[idx] <= wdata[15:8];
      if (sel[2]) bank2[idx] <= wdata[23:16];
      if (sel[3]) bank3[idx] <= wdata[31:24];
    end
  end

  assign rdata = (rst && ce == ENABLE && we == READ) ?
                 {bank3[idx], bank2[idx], bank1[idx], bank0[idx]} : '0;
endmodule

// File: rtl/inst_rom.sv
// Word-addressed instruction ROM, preloaded by the simulation environment.
// Reads as zero (nop) while disabled or in reset.
module inst_rom
  import defines::*;
#(
  parameter int INST_MEM_WORDS = INST_MEM_NUM
) (
  input  logic                     rst,
  input  logic                     ce,
  input  logic [INST_ADDR_BUS-1:0] addr,
  output logic [DATA_BUS-1:0]      data
);
  logic [DATA_BUS-1:0] inst_mem [0:INST_MEM_WORDS-1];
  logic unused_addr;

  // Upper bits are dropped so the ROM aliases modulo its size.
  assign unused_addr = ^{addr[INST_ADDR_BUS-1:MEM_IDX_W+2], addr[1:0]};
  assign data = (rst && ce == ENABLE) ? inst_mem[mem_idx(addr)] : '0;
endmodule

// File: rtl/openmips.sv
// Reduced five-stage MIPS32 core (IF/ID/EX/MEM/WB): forwarding into ID from
// EX and MEM, one-cycle load-use stall, LL/SC through LLbit, little-endian bytes.
module openmips
  import defines::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);
  logic [31:0] pc, id_inst, rf_rs, rf_rt, op_a, op_b, imm_ext;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, d_wa;
  logic        stall, ex_is_load, d_we, d_sext, d_use_imm, d_rd_rs, d_rd_rt;
  alu_op_e     d_alu, ex_alu;
  mem_op_e     d_mem, ex_mem, mem_op;
  logic [31:0] ex_a, ex_b, ex_imm, ex_op2, ex_res;
  logic        ex_use_imm, ex_we, mem_we, wb_we, llbit;
  logic [4:0]  ex_wa, mem_wa, wb_wa;
  logic [31:0] mem_alu, mem_sd, mem_res, wb_res;
  logic [7:0]  mem_byte;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rom_ce <= DISABLE;
      pc     <= '0;
    end else begin
      rom_ce <= ENABLE;
      if (rom_ce && !stall) pc <= pc + 32'd4;
    end
  end
  assign rom_addr = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        id_inst <= '0;
    else if (!stall) id_inst <= rom_data;
  end

  assign op    = id_inst[31:26];
  assign rs    = id_inst[25:21];
  assign rt    = id_inst[20:16];
  assign rd    = id_inst[15:11];
  assign funct = id_inst[5:0];

  always_comb begin
    d_we = 1'b0;  d_wa = rt;  d_alu = ALU_OR;  d_mem = MEM_NONE;
    d_sext = 1'b0;  d_use_imm = 1'b1;  d_rd_rs = 1'b1;  d_rd_rt = 1'b0;
    case (op)
      OP_SPECIAL: begin
        d_use_imm = 1'b0;  d_rd_rt = 1'b1;  d_wa = rd;
        if (id_inst[10:6] == 5'd0) begin
          d_we = 1'b1;
          case (funct)
            6'b100001: d_alu = ALU_ADD;
            6'b100011: d_alu = ALU_SUB;
            6'b100100: d_alu = ALU_AND;
            6'b100101: d_alu = ALU_OR;
            6'b100110: d_alu = ALU_XOR;
            default:   d_we  = 1'b0;
          endcase
        end
      end
      OP_ORI:            d_we = 1'b1;
      OP_ANDI:           begin d_we = 1'b1; d_alu = ALU_AND; end
      OP_XORI:           begin d_we = 1'b1; d_alu = ALU_XOR; end
      OP_LUI:            begin d_we = 1'b1; d_alu = ALU_LUI; end
      OP_ADDI, OP_ADDIU: begin d_we = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; end
      OP_LW:  begin d_we = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_LW;  end
      OP_LB:  begin d_we = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_LB;  end
      OP_LBU: begin d_we = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_LBU; end
      OP_LL:  begin d_we = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_LL;  end
      OP_SB:  begin d_rd_rt = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_SB; end
      OP_SW:  begin d_rd_rt = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_SW; end
      OP_SC:  begin d_we = 1'b1; d_rd_rt = 1'b1; d_alu = ALU_ADD; d_sext = 1'b1; d_mem = MEM_SC; end
      OP_COP0: if (id_inst[25] && funct == 6'b011000) d_mem = MEM_ERET;
      default: ;
    endcase
  end

  assign imm_ext = d_sext ? {{16{id_inst[15]}}, id_inst[15:0]} : {16'h0, id_inst[15:0]};

  // Youngest producer wins; a load still in EX is covered by the stall below.
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a == 5'd0)                  return '0;
    else if (ex_we && ex_wa == a)   return ex_res;
    else if (mem_we && mem_wa == a) return mem_res;
    else                            return rf;
  endfunction

  assign op_a = fwd(rs, rf_rs);
  assign op_b = fwd(rt, rf_rt);

  assign ex_is_load = ex_mem inside {MEM_LW, MEM_LB, MEM_LBU, MEM_LL, MEM_SC};
  assign stall = ex_is_load && ex_we && ex_wa != 5'd0 &&
                 ((d_rd_rs && ex_wa == rs) || (d_rd_rt && ex_wa == rt));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_a <= '0;  ex_b <= '0;  ex_imm <= '0;  ex_use_imm <= 1'b0;
      ex_alu <= ALU_OR;  ex_mem <= MEM_NONE;  ex_we <= 1'b0;  ex_wa <= '0;
    end else begin
      ex_a <= op_a;  ex_b <= op_b;  ex_imm <= imm_ext;  ex_use_imm <= d_use_imm;
      ex_alu <= d_alu;  ex_wa <= d_wa;
      ex_mem <= stall ? MEM_NONE : d_mem;
      ex_we  <= stall ? 1'b0 : d_we;
    end
  end

  assign ex_op2 = ex_use_imm ? ex_imm : ex_b;

  always_comb begin
    ex_res = ex_a | ex_op2;
    case (ex_alu)
      ALU_AND: ex_res = ex_a & ex_op2;
      ALU_XOR: ex_res = ex_a ^ ex_op2;
      ALU_ADD: ex_res = ex_a + ex_op2;
      ALU_SUB: ex_res = ex_a - ex_op2;
      ALU_LUI: ex_res = {ex_op2[15:0], 16'h0};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_op <= MEM_NONE;  mem_we <= 1'b0;  mem_wa <= '0;  mem_alu <= '0;  mem_sd <= '0;
    end else begin
      mem_op <= ex_mem;  mem_we <= ex_we;  mem_wa <= ex_wa;  mem_alu <= ex_res;  mem_sd <= ex_b;
    end
  end

  always_comb begin
    ram_ce = DISABLE;  ram_we = READ;  ram_sel = 4'h0;  ram_addr = mem_alu;  ram_wdata = '0;
    case (mem_op)
      MEM_LW, MEM_LL:  begin ram_ce = ENABLE; ram_sel = 4'hf; end
      MEM_LB, MEM_LBU: begin ram_ce = ENABLE; ram_sel = 4'b0001 << mem_alu[1:0]; end
      MEM_SW: begin ram_ce = ENABLE; ram_we = WRITE; ram_sel = 4'hf; ram_wdata = mem_sd; end
      MEM_SB: begin
        ram_ce = ENABLE;  ram_we = WRITE;  ram_sel = 4'b0001 << mem_alu[1:0];
        ram_wdata = {4{mem_sd[7:0]}};
      end
      MEM_SC: if (llbit) begin ram_ce = ENABLE; ram_we = WRITE; ram_sel = 4'hf; ram_wdata = mem_sd; end
      default: ;
    endcase
  end

  assign mem_byte = ram_rdata[{mem_alu[1:0], 3'b000} +: 8];

  always_comb begin
    mem_res = mem_alu;
    case (mem_op)
      MEM_LW, MEM_LL:  mem_res = ram_rdata;
      MEM_LB, MEM_LBU: mem_res = {{24{mem_op == MEM_LB && mem_byte[7]}}, mem_byte};
      MEM_SC:          mem_res = {31'h0, llbit};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    llbit <= 1'b0;
    else if (mem_op == MEM_LL)   llbit <= 1'b1;
    else if (mem_op == MEM_ERET) llbit <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_we <= 1'b0;  wb_wa <= '0;  wb_res <= '0;
    end else begin
      wb_we <= mem_we;  wb_wa <= mem_wa;  wb_res <= mem_res;
    end
  end

  regfile regfile1 (
    .clk(clk), .rst(rst), .we(wb_we), .waddr(wb_wa), .wdata(wb_res),
    .raddr1(rs), .rdata1(rf_rs), .raddr2(rt), .rdata2(rf_rt)
  );
endmodule

// File: rtl/regfile.sv
// 32 x 32 general-purpose register file; $0 reads zero, same-cycle write is
// bypassed to the read ports so ID sees the value WB is retiring.
module regfile
  import defines::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  output logic [31:0] rdata1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0) ? '0 : (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? '0 : (we && waddr == raddr2) ? wdata : regs[raddr2];
endmodule

// File: rtl/openmips_min_sopc.sv
// Minimal OpenMIPS SoC: core, instruction ROM and data RAM on one clock.
module openmips_min_sopc
  import defines::*;
#(
  parameter int INST_MEM_WORDS = INST_MEM_NUM,
  parameter int DATA_MEM_WORDS = DATA_MEM_NUM
) (
  input logic clk,
  input logic rst
);
  logic        rom_ce, ram_ce, ram_we;
  logic [3:0]  ram_sel;
  logic [31:0] rom_addr, rom_data, ram_addr, ram_wdata, ram_rdata;

  openmips openmips0 (
    .clk(clk), .rst(rst),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_sel(ram_sel), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  inst_rom #(.INST_MEM_WORDS(INST_MEM_WORDS)) inst_rom0 (
    .rst(rst), .ce(rom_ce), .addr(rom_addr), .data(rom_data)
  );

  data_ram #(.DATA_MEM_WORDS(DATA_MEM_WORDS)) data_ram0 (
    .clk(clk), .rst(rst), .ce(ram_ce), .we(ram_we), .sel(ram_sel),
    .addr(ram_addr), .wdata(ram_wdata), .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_openmips_min_sopc.sv
// Directed bench for the OpenMIPS minimal SoC: LL/SC program, reset behaviour,
// byte enables, load-use stall and address aliasing.
module tb_openmips_min_sopc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  openmips_min_sopc dut (.clk(clk), .rst(rst));

  localparam logic [31:0] PROG_LLSC [14] = '{
    32'h34011234, 32'hAC010000, 32'h34015678, 32'hE0010000, 32'h8C010000, 32'h00000000,
    32'h34010000, 32'hC0010000, 32'h00000000, 32'h20210001, 32'hE0010000, 32'h8C010000,
    32'h00000000, 32'h00000000};
  localparam logic [31:0] PROG_BYTE [14] = '{
    32'h3C021122, 32'h34423344, 32'hAC020008, 32'h340300AA, 32'hA0030009, 32'h8C040008,
    32'h80050009, 32'h90060009, 32'h3C070008, 32'hACE20000, 32'h8C080000, 32'h01085021,
    32'h00864821, 32'h00000000};
  localparam logic [31:0] EXP_R1 [12] = '{
    32'h1234, 32'h1234, 32'h5678, 32'h0, 32'h1234, 32'h1234,
    32'h0, 32'h1234, 32'h1234, 32'h1235, 32'h1, 32'h1235};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic load_rom(input bit byte_prog);
    for (int i = 0; i < 64; i++) dut.inst_rom0.inst_mem[i] = '0;
    for (int i = 0; i < 14; i++)
      dut.inst_rom0.inst_mem[i] = byte_prog ? PROG_BYTE[i] : PROG_LLSC[i];
  endtask

  function automatic logic [31:0] ram_word(input int idx);
    return {dut.data_ram0.bank3[idx], dut.data_ram0.bank2[idx],
            dut.data_ram0.bank1[idx], dut.data_ram0.bank0[idx]};
  endfunction

  // Called right after reset release on a falling edge.
  task automatic check_r1_seq(input string pfx);
    repeat (5) @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_r1_%0d", pfx, k), dut.openmips0.regfile1.regs[1], EXP_R1[k]);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    dut.data_ram0.bank0[0] = 8'hEF;
    dut.data_ram0.bank1[0] = 8'hBE;
    dut.data_ram0.bank2[0] = 8'hAD;
    dut.data_ram0.bank3[0] = 8'hDE;
    load_rom(1'b0);

    repeat (4) begin
      @(negedge clk);
      chk("rst_rom_data", dut.rom_data, 32'h0);
      chk("rst_r1", dut.openmips0.regfile1.regs[1], 32'h0);
    end
    chk("rst_ram0_kept", ram_word(0), 32'hDEADBEEF);

    rst = 1'b1;
    check_r1_seq("run1");
    repeat (5) @(posedge clk);
    #1;
    chk("llsc_ram0", ram_word(0), 32'h00001235);

    @(negedge clk) rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (13) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_pc", dut.rom_addr, 32'h0);
    chk("mid_rom_data", dut.rom_data, 32'h0);
    chk("mid_r1", dut.openmips0.regfile1.regs[1], 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    check_r1_seq("run2");

    @(negedge clk) rst = 1'b0;
    load_rom(1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("byte_ram8", ram_word(2), 32'h1122AA44);
    chk("byte_bank1_2", {24'h0, dut.data_ram0.bank1[2]}, 32'h000000AA);
    chk("byte_lw_r4", dut.openmips0.regfile1.regs[4], 32'h1122AA44);
    chk("byte_lb_r5", dut.openmips0.regfile1.regs[5], 32'hFFFFFFAA);
    chk("byte_lbu_r6", dut.openmips0.regfile1.regs[6], 32'h000000AA);
    chk("alias_ram0", ram_word(0), 32'h11223344);
    chk("alias_lw_r8", dut.openmips0.regfile1.regs[8], 32'h11223344);
    chk("loaduse_r10", dut.openmips0.regfile1.regs[10], 32'h22446688);
    chk("addu_r9", dut.openmips0.regfile1.regs[9], 32'h1122AAEE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/openmips_min_sopc.md
# openmips_min_sopc

Minimal system-on-chip top for the OpenMIPS core: one `openmips` pipeline core, one word-addressed instruction ROM and one byte-banked data RAM, all on a single clock. The block is the simulation and verification top for ISA tests. Benches preload the ROM, release reset and then check architectural registers and memory cycle by cycle. This block owns the ROM, the RAM and their wiring to the core. The core, including its register file and LL/SC `LLbit` logic, is an existing block.

## Interface
- `INST_MEM_WORDS`, default 131072: ROM depth in 32-bit words. The ROM index is `addr[18:2]`.
- `DATA_MEM_WORDS`, default 131072: RAM depth in words. Each of the four byte banks has this depth.
- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  reset, asynchronous, active-low. It is applied to the core, the ROM interface and the RAM interface.
- The block has no other top-level ports.
- Fixed hierarchy names, used by benches:
  - `openmips0`, which contains `regfile1.regs[0:31]`
  - `inst_rom0.inst_mem[]`
  - `data_ram0.bank0..bank3[]`, where `bank0` holds bits 7:0.

## Operation
- Core-to-ROM wiring:
  - `rom_ce`: 1 bit, driven by the core.
  - `rom_addr`: 32 bits, driven by the core.
  - `rom_data`: 32 bits, driven by the ROM.
- ROM read behaviour:
  - Combinational: `rom_data = inst_mem[rom_addr[18:2]]`.
  - When `rom_ce` = 0, `rom_data` = 0, which decodes as `nop`.
  - The ROM is loaded only by `$readmemh` from the bench. Unloaded words read as X.
- Core-to-RAM wiring:
  - `ram_ce`: 1 bit.
  - `ram_we`: 1 bit.
  - `ram_sel`: 4 bits, byte enables; `sel[3]` selects bits 31:24.
  - `ram_addr`: 32 bits.
  - `ram_wdata`: 32 bits, from the core.
  - `ram_rdata`: 32 bits, to the core.
- RAM write:
  - Synchronous on the rising edge of `clk`.
  - Occurs when `ram_ce` = 1 and `ram_we` = 1.
  - Each enabled byte `i` is written as `bank_i[addr[18:2]] <= wdata[8i+7:8i]`.
- RAM read:
  - Combinational: the full word `{bank3, bank2, bank1, bank0}[addr[18:2]]`.
  - Read when `ram_ce` = 1 and `ram_we` = 0; otherwise `ram_rdata` = 0.
  - The core performs byte and halfword extraction and extension.
- LL/SC semantics, implemented by the core and required of the system:
  - `ll` loads a word and sets `LLbit`.
  - `sc` writes memory and returns rt = 1 only if `LLbit` = 1; otherwise there is no memory write and rt = 0.
  - `LLbit` clears on reset and on exception return.
- Address bits above 18 are ignored, so accesses alias modulo the memory size.

## Timing
- Reset (`rst` = 0): the core is held, its PC is 0 and `rom_ce` = 0.
  - ROM and RAM contents are not cleared by reset.
  - All core registers read 0.
- The first fetch (PC = 0) occurs in the first rising edge after `rst` goes high.
- Write-back latency is 5 stages. Instruction k (0-based) becomes visible in the register file 5 cycles after its fetch edge. With no stalls, results appear one per cycle.
- Load-use hazards stall the pipeline for one cycle. The core provides this.
- A store is visible to a load issued at least one cycle later. Same-edge RAM write followed by a combinational read is coherent.
- Reset mid-program returns PC to 0 asynchronously. An in-flight store that has not reached its clock edge is dropped.

## Structure
- Shared package `defines`. It holds:
  - enable/disable constants and the `WRITE`/`READ` constants
  - `InstAddrBus` and `DataBus` widths
  - memory depth constants and the ROM/RAM index width, which is 17 bits
  - the `LL`/`SC` opcodes
- Sub-modules:
  - `openmips`: existing core.
  - `inst_rom`: trivial.
  - `data_ram`: the natural new sub-module. It contains four byte banks with per-byte write enables.
- The top module contains only instantiation and wiring.

## Test plan
- LL/SC program, 14 words. Register `$1` must read, one cycle apart starting 6 cycles after reset release: `1234, 1234, 5678, 0, 1234, 1234, 0, 1234, 1234, 1235, 1, 1235`. The program, in order:
  - `ori $1,0x1234`
  - `sw $1,0`
  - `ori $1,0x5678`
  - `sc $1,0`: fails, no write, `$1` = 0
  - `lw`
  - `nop`
  - `ori $1,$0,0`
  - `ll $1,0`
  - `nop`
  - `addi $1,1`
  - `sc $1,0`: succeeds, `$1` = 1
  - `lw`
  - Final RAM word 0 must be `0x00001235`.
- Byte enables: `sw 0x11223344` to address 8, then `sb 0xAA` to address 9.
  - RAM word at 0x0008 must read `0x1122AA44`.
  - `bank1[2]` must read `0xAA`.
- Disabled ROM: while `rst` = 0, `rom_data` must be 0 and no register or RAM changes.
- Reset mid-run: assert `rst` low during the LL/SC program, then release.
  - The program restarts from PC 0.
  - The same `$1` sequence must repeat.
  - The first `sc` must fail, because `LLbit` was cleared.
- Address aliasing: a store to `0x0008_0000` must write RAM word 0.
